el2_pmp_checker_pipe: RTL and testbench

EL2_PMP_CHECKER_PIPE -- requirements
Module: el2_pmp_checker_pipe

---
 rtl/el2_pmp_checker_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_el2_pmp_checker_pipe.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/el2_pmp_checker_pipe.sv
// el2_pmp_checker_pipe
// Multi-channel PMP access checker. A shared table of pmpcfg/pmpaddr entries
// is checked by PMP_CHANNELS independent one-deep pipeline stages. The first
// faulting response is captured, and faulting responses are counted with
// saturation.
module el2_pmp_checker_pipe #(
  parameter int PMP_CHANNELS = 3,
  parameter int PMP_ENTRIES  = 16,
  parameter bit NOMATCH_ERR  = 1'b0,
  localparam int IDX_W = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1,
  localparam int CH_W  = (PMP_CHANNELS > 1) ? $clog2(PMP_CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic                      cfg_wr_en,
  input  logic [IDX_W-1:0]          cfg_wr_idx,
  input  logic [7:0]                cfg_wr_data,
  input  logic                      addr_wr_en,
  input  logic [IDX_W-1:0]          addr_wr_idx,
  input  logic [31:0]               addr_wr_data,
  input  logic [PMP_CHANNELS-1:0]   req_valid,
  output logic [PMP_CHANNELS-1:0]   req_ready,
  input  logic [PMP_CHANNELS*32-1:0] req_addr,
  input  logic [PMP_CHANNELS*3-1:0] req_type,
  output logic [PMP_CHANNELS-1:0]   rsp_valid,
  input  logic [PMP_CHANNELS-1:0]   rsp_ready,
  output logic [PMP_CHANNELS-1:0]   rsp_err,
  output logic                      fault_valid,
  output logic [31:0]               fault_addr,
  output logic [CH_W-1:0]           fault_chan,
  output logic [2:0]                fault_type,
  input  logic                      fault_clr,
  output logic [15:0]               fault_cnt
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_TOR   = 2'd1,
    MODE_NA4   = 2'd2,
    MODE_NAPOT = 2'd3
  } pmp_mode_e;

  logic [7:0]              cfg_q  [PMP_ENTRIES];
  logic [31:0]             addr_q [PMP_ENTRIES];
  logic [PMP_ENTRIES-1:0]  addr_locked;
  logic [PMP_CHANNELS-1:0] chk_err;
  logic [PMP_CHANNELS-1:0] accept;
  logic [PMP_CHANNELS-1:0] load_err;

  logic                    sel_found;
  logic [CH_W-1:0]         sel_chan;
  logic [31:0]             sel_addr;
  logic [2:0]              sel_type;
  logic [3:0]              err_count;
  logic [15:0]             cnt_base;
  logic [16:0]             cnt_sum;
  logic [15:0]             cnt_next;

  // Reserved cfg bits are never stored, so these input bits are dropped on purpose.
  logic unused_cfg_rsvd;
  assign unused_cfg_rsvd = ^cfg_wr_data[6:5];

  // An address register is frozen by its own lock, or by a locked TOR entry
  // directly above it that uses it as a lower bound.
  for (genvar i = 0; i < PMP_ENTRIES; i++) begin : g_lock
    if (i + 1 < PMP_ENTRIES) begin : g_next
      assign addr_locked[i] = cfg_q[i][7] |
                              (cfg_q[i+1][7] & (cfg_q[i+1][4:3] == MODE_TOR));
    end else begin : g_last
      assign addr_locked[i] = cfg_q[i][7];
    end
  end

  // Entry table: writes land at the clock edge unless the target is locked.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        if (cfg_wr_en && (cfg_wr_idx == IDX_W'(i)) && !cfg_q[i][7]) begin
          cfg_q[i] <= {cfg_wr_data[7], 2'b00, cfg_wr_data[4:0]};
        end
        if (addr_wr_en && (addr_wr_idx == IDX_W'(i)) && !addr_locked[i]) begin
          addr_q[i] <= addr_wr_data;
        end
      end
    end
  end

  // Per-channel address matching and permission check against the current table.
  for (genvar c = 0; c < PMP_CHANNELS; c++) begin : g_chan
    logic [31:0]            word_addr;
    logic [2:0]             acc_type;
    logic [PMP_ENTRIES-1:0] hits;
    logic                   found;
    logic                   ch_err;

    assign word_addr = {2'b00, req_addr[c*32+2 +: 30]};
    assign acc_type  = req_type[c*3 +: 3];

    for (genvar i = 0; i < PMP_ENTRIES; i++) begin : g_ent
      logic [31:0] lower;
      logic [31:0] napot_mask;
      logic        hit;

      if (i == 0) begin : g_base
        assign lower = '0;
      end else begin : g_prev
        assign lower = addr_q[i-1];
      end

      // addr ^ (addr+1) sets bits 0..k for k trailing ones; all-ones addr gives an empty mask.
      assign napot_mask = ~(addr_q[i] ^ (addr_q[i] + 32'd1));

      // Region test for this entry according to its address-matching mode.
      always_comb begin
        hit = 1'b0;
        case (cfg_q[i][4:3])
          MODE_TOR:   hit = (word_addr >= lower) && (word_addr < addr_q[i]);
          MODE_NA4:   hit = (word_addr == addr_q[i]);
          MODE_NAPOT: hit = ((word_addr ^ addr_q[i]) & napot_mask) == 32'd0;
          default:    hit = 1'b0;
        endcase
      end

      assign hits[i] = hit;
    end

    // Lowest matching entry decides; an empty access type never faults.
    always_comb begin
      found  = 1'b0;
      ch_err = NOMATCH_ERR;
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        if (!found && hits[i]) begin
          found  = 1'b1;
          ch_err = |(acc_type & ~cfg_q[i][2:0]);
        end
      end
      if (acc_type == 3'b000) begin
        ch_err = 1'b0;
      end
    end

    assign chk_err[c] = ch_err;
  end

  assign req_ready = ~rsp_valid | rsp_ready;
  assign accept    = req_valid & req_ready;
  assign load_err  = accept & chk_err;

  // One-deep response stage per channel; a response holds until consumed.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rsp_valid <= '0;
      rsp_err   <= '0;
    end else begin
      for (int c = 0; c < PMP_CHANNELS; c++) begin
        if (accept[c]) begin
          rsp_valid[c] <= 1'b1;
          rsp_err[c]   <= chk_err[c];
        end else if (rsp_ready[c]) begin
          rsp_valid[c] <= 1'b0;
        end
      end
    end
  end

  // Pick the lowest faulting channel this cycle and count all faulting loads.
  always_comb begin
    sel_found = 1'b0;
    sel_chan  = '0;
    sel_addr  = '0;
    sel_type  = '0;
    err_count = '0;
    for (int c = 0; c < PMP_CHANNELS; c++) begin
      if (load_err[c]) begin
        err_count = err_count + 4'd1;
        if (!sel_found) begin
          sel_found = 1'b1;
          sel_chan  = CH_W'(c);
          sel_addr  = req_addr[c*32 +: 32];
          sel_type  = req_type[c*3 +: 3];
        end
      end
    end
  end

  // Saturating fault counter; a clear restarts from zero before this cycle's faults.
  always_comb begin
    cnt_base = fault_clr ? 16'd0 : fault_cnt;
    cnt_sum  = {1'b0, cnt_base} + {13'd0, err_count};
    cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  // First-fault capture: clear happens first, so a same-cycle fault is still caught.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fault_chan  <= '0;
      fault_type  <= '0;
      fault_cnt   <= '0;
    end else begin
      if (fault_clr) begin
        fault_valid <= 1'b0;
        fault_addr  <= '0;
        fault_chan  <= '0;
        fault_type  <= '0;
      end
      if ((fault_clr || !fault_valid) && sel_found) begin
        fault_valid <= 1'b1;
        fault_addr  <= sel_addr;
        fault_chan  <= sel_chan;
        fault_type  <= sel_type;
      end
      fault_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_el2_pmp_checker_pipe.sv
// Testbench for el2_pmp_checker_pipe: directed scenarios plus randomized
// traffic, checked by a scoreboard fed from a region-based reference model.
module tb_el2_pmp_checker_pipe;

  localparam int NCH     = 3;
  localparam int NENT    = 16;
  localparam bit NOMATCH = 1'b1;

  logic              clk;
  logic              rst_l;
  logic              cfg_wr_en;
  logic [3:0]        cfg_wr_idx;
  logic [7:0]        cfg_wr_data;
  logic              addr_wr_en;
  logic [3:0]        addr_wr_idx;
  logic [31:0]       addr_wr_data;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [NCH*32-1:0] req_addr;
  logic [NCH*3-1:0]  req_type;
  logic [NCH-1:0]    rsp_valid;
  logic [NCH-1:0]    rsp_ready;
  logic [NCH-1:0]    rsp_err;
  logic              fault_valid;
  logic [31:0]       fault_addr;
  logic [1:0]        fault_chan;
  logic [2:0]        fault_type;
  logic              fault_clr;
  logic [15:0]       fault_cnt;

  el2_pmp_checker_pipe #(
    .PMP_CHANNELS(NCH),
    .PMP_ENTRIES (NENT),
    .NOMATCH_ERR (NOMATCH)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_idx  (cfg_wr_idx),
    .cfg_wr_data (cfg_wr_data),
    .addr_wr_en  (addr_wr_en),
    .addr_wr_idx (addr_wr_idx),
    .addr_wr_data(addr_wr_data),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_type    (req_type),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_err     (rsp_err),
    .fault_valid (fault_valid),
    .fault_addr  (fault_addr),
    .fault_chan  (fault_chan),
    .fault_type  (fault_type),
    .fault_clr   (fault_clr),
    .fault_cnt   (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  logic [7:0]  m_cfg  [NENT];
  logic [31:0] m_addr [NENT];
  bit          m_rv   [NCH];
  bit          exp_q  [NCH][$];
  bit          m_fv;
  logic [31:0] m_faddr;
  int          m_fchan;
  logic [2:0]  m_ftype;
  int          m_fcnt;

  int n_checks;
  int n_fails;
  int ch1_seen;

  int mon_nerr;
  bit mon_e;
  int mon_j;
  bit mon_cw;
  bit mon_aw;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NENT; i++) begin
      m_cfg[i]  = '0;
      m_addr[i] = '0;
    end
    for (int c = 0; c < NCH; c++) begin
      m_rv[c] = 1'b0;
      exp_q[c].delete();
    end
    m_fv    = 1'b0;
    m_faddr = '0;
    m_fchan = 0;
    m_ftype = '0;
    m_fcnt  = 0;
  endtask

  // Region-based reference: each entry is turned into a [base, limit) word range.
  function automatic bit refErr(input logic [31:0] byte_addr, input logic [2:0] acc);
    longint unsigned wa, lo, entry, size, base;
    int k;
    bit hit;
    if (acc == 3'b000) return 1'b0;
    wa = 64'(byte_addr >> 2);
    for (int i = 0; i < NENT; i++) begin
      entry = 64'(m_addr[i]);
      hit   = 1'b0;
      case (m_cfg[i][4:3])
        2'd1: begin
          if (i > 0) lo = 64'(m_addr[i-1]);
          else lo = 64'd0;
          hit = (wa >= lo) && (wa < entry);
        end
        2'd2: hit = (wa == entry);
        2'd3: begin
          k = 0;
          while (k < 32 && m_addr[i][k]) k++;
          if (k == 32) hit = 1'b1;
          else begin
            size = 64'd1 << (k + 1);
            base = (entry / size) * size;
            hit  = (wa >= base) && (wa < base + size);
          end
        end
        default: hit = 1'b0;
      endcase
      if (hit) return (acc & ~m_cfg[i][2:0]) != 3'b000;
    end
    return NOMATCH;
  endfunction

  // Monitor/scoreboard: compare what the DUT presents, then advance the model
  // across the coming clock edge.
  always @(negedge clk) begin
    if (!rst_l) begin
      modelReset();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        checkOutput($sformatf("req_ready[%0d]", c), 32'(req_ready[c]),
                    32'(!m_rv[c] || rsp_ready[c]));
        checkOutput($sformatf("rsp_valid[%0d]", c), 32'(rsp_valid[c]), 32'(m_rv[c]));
        if (rsp_valid[c] || m_rv[c]) begin
          if (exp_q[c].size() == 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL rsp_unexpected[%0d]: actual=valid required=no response", c);
          end else begin
            checkOutput($sformatf("rsp_err[%0d]", c), 32'(rsp_err[c]), 32'(exp_q[c][0]));
            if (rsp_ready[c] && m_rv[c]) void'(exp_q[c].pop_front());
          end
        end
        if (c == 1 && rsp_valid[1] && rsp_ready[1]) ch1_seen++;
      end
      checkOutput("fault_valid", 32'(fault_valid), 32'(m_fv));
      checkOutput("fault_addr", fault_addr, m_faddr);
      checkOutput("fault_chan", 32'(fault_chan), 32'(m_fchan));
      checkOutput("fault_type", 32'(fault_type), 32'(m_ftype));
      checkOutput("fault_cnt", 32'(fault_cnt), 32'(m_fcnt));

      if (fault_clr) begin
        m_fv    = 1'b0;
        m_faddr = '0;
        m_fchan = 0;
        m_ftype = '0;
        m_fcnt  = 0;
      end
      mon_nerr = 0;
      for (int c = 0; c < NCH; c++) begin
        if (req_valid[c] && (!m_rv[c] || rsp_ready[c])) begin
          mon_e = refErr(req_addr[c*32 +: 32], req_type[c*3 +: 3]);
          exp_q[c].push_back(mon_e);
          m_rv[c] = 1'b1;
          if (mon_e) begin
            mon_nerr++;
            if (!m_fv) begin
              m_fv    = 1'b1;
              m_faddr = req_addr[c*32 +: 32];
              m_fchan = c;
              m_ftype = req_type[c*3 +: 3];
            end
          end
        end else if (rsp_ready[c]) begin
          m_rv[c] = 1'b0;
        end
      end
      m_fcnt = (m_fcnt + mon_nerr > 65535) ? 65535 : m_fcnt + mon_nerr;

      mon_cw = cfg_wr_en && !m_cfg[cfg_wr_idx][7];
      mon_j  = int'(addr_wr_idx);
      mon_aw = addr_wr_en && !m_cfg[mon_j][7];
      if (mon_j + 1 < NENT) begin
        if (m_cfg[mon_j+1][7] && m_cfg[mon_j+1][4:3] == 2'd1) mon_aw = 1'b0;
      end
      if (mon_cw) m_cfg[cfg_wr_idx] = cfg_wr_data & 8'h9F;
      if (mon_aw) m_addr[mon_j] = addr_wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int c, input logic [31:0] a, input logic [2:0] t);
    req_valid[c]        = 1'b1;
    req_addr[c*32 +: 32] = a;
    req_type[c*3 +: 3]   = t;
  endtask

  task automatic writeEntry(input bit do_cfg, input int ci, input logic [7:0] cd,
                            input bit do_addr, input int ai, input logic [31:0] ad);
    cfg_wr_en    = do_cfg;
    cfg_wr_idx   = 4'(ci);
    cfg_wr_data  = cd;
    addr_wr_en   = do_addr;
    addr_wr_idx  = 4'(ai);
    addr_wr_data = ad;
    tick();
    cfg_wr_en  = 1'b0;
    addr_wr_en = 1'b0;
  endtask

  function automatic logic [7:0] randCfg();
    return {($urandom_range(0, 31) == 0), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
  endfunction

  function automatic logic [31:0] randAddr();
    int k;
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = 32'($urandom_range(0, 32'h4FF));
      1: begin
        k = $urandom_range(0, 10);
        v = (32'($urandom_range(0, 32'h4FF)) & ~((32'd1 << (k + 1)) - 32'd1)) |
            ((32'd1 << k) - 32'd1);
      end
      2: v = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 32'h4FF));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] randReqAddr();
    if ($urandom_range(0, 9) < 7)
      return (32'($urandom_range(0, 32'h4FF)) << 2) | 32'($urandom_range(0, 3));
    return $urandom;
  endfunction

  int snap;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    ch1_seen = 0;
    rst_l = 1'b0;
    cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_wr_data = '0;
    addr_wr_en = 1'b0; addr_wr_idx = '0; addr_wr_data = '0;
    req_valid = '0; req_addr = '0; req_type = '0;
    rsp_ready = '1;
    fault_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_fault_valid", 32'(fault_valid), 32'd0);
    checkOutput("reset_fault_cnt", 32'(fault_cnt), 32'd0);
    rst_l = 1'b1;
    tick();

    // 8 KiB NAPOT region at 0, read-only
    writeEntry(1'b1, 0, 8'h19, 1'b1, 0, 32'h0000_03FF);
    applyStimulus(0, 32'h1FFC, 3'b001);
    tick();
    applyStimulus(0, 32'h1FFC, 3'b010);
    tick();
    req_valid = '0;
    tick();
    tick();
    checkOutput("napot_fault_valid", 32'(fault_valid), 32'd1);
    checkOutput("napot_fault_addr", fault_addr, 32'h1FFC);
    checkOutput("napot_fault_type", 32'(fault_type), 32'd2);
    checkOutput("napot_fault_cnt", 32'(fault_cnt), 32'd1);

    // TOR entry 1 over [0x400, 0x800) words, RWX
    writeEntry(1'b0, 0, 8'h00, 1'b1, 0, 32'h400);
    writeEntry(1'b1, 1, 8'h0F, 1'b1, 1, 32'h800);
    applyStimulus(1, 32'h1000, 3'b001);
    tick();
    applyStimulus(1, 32'h2000, 3'b001);
    tick();
    req_valid = '0;
    tick();

    // Locked TOR entry 2 freezes its own cfg and the address below it
    writeEntry(1'b1, 2, 8'h89, 1'b1, 2, 32'hC00);
    writeEntry(1'b1, 2, 8'h00, 1'b1, 1, 32'h1234);
    applyStimulus(2, 32'h2000, 3'b001);
    tick();
    applyStimulus(2, 32'h2004, 3'b010);
    tick();
    req_valid = '0;
    tick();

    // Stall channel 0 while channel 1 streams
    rsp_ready[0] = 1'b0;
    applyStimulus(0, 32'h2000, 3'b001);
    tick();
    applyStimulus(0, 32'h2004, 3'b010);
    snap = ch1_seen;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 32'h1000 + 32'(i * 4), 3'(1 + (i % 3)));
      tick();
      checkOutput("stall_req_ready0", 32'(req_ready[0]), 32'd0);
      checkOutput("stall_rsp_valid0", 32'(rsp_valid[0]), 32'd1);
      checkOutput("stall_rsp_err0", 32'(rsp_err[0]), 32'd0);
    end
    req_valid[1] = 1'b0;
    tick();
    checkOutput("stall_ch1_done", 32'(ch1_seen - snap), 32'd5);
    rsp_ready[0] = 1'b1;
    tick();
    req_valid = '0;
    tick();

    // Simultaneous faults on channels 0 and 2 together with a clear
    applyStimulus(0, 32'h2004, 3'b010);
    applyStimulus(2, 32'h2004, 3'b010);
    fault_clr = 1'b1;
    tick();
    req_valid = '0;
    fault_clr = 1'b0;
    tick();
    checkOutput("dual_fault_chan", 32'(fault_chan), 32'd0);
    checkOutput("dual_fault_valid", 32'(fault_valid), 32'd1);
    checkOutput("dual_fault_cnt", 32'(fault_cnt), 32'd2);

    // Reset with three responses pending
    rsp_ready = '0;
    for (int c = 0; c < NCH; c++) applyStimulus(c, 32'h1000, 3'b001);
    tick();
    req_valid = '0;
    tick();
    rst_l = 1'b0;
    #1;
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_fault_cnt", 32'(fault_cnt), 32'd0);
    tick();
    rsp_ready = '1;
    rst_l = 1'b1;
    tick();

    // Randomized traffic with a reset in the middle
    for (int cyc = 0; cyc < 1500; cyc++) begin
      cfg_wr_en    = ($urandom_range(0, 7) == 0);
      cfg_wr_idx   = 4'($urandom_range(0, NENT - 1));
      cfg_wr_data  = randCfg();
      addr_wr_en   = ($urandom_range(0, 3) == 0);
      addr_wr_idx  = 4'($urandom_range(0, NENT - 1));
      addr_wr_data = randAddr();
      for (int c = 0; c < NCH; c++) begin
        req_valid[c] = ($urandom_range(0, 3) != 0);
        req_addr[c*32 +: 32] = randReqAddr();
        req_type[c*3 +: 3] = 3'($urandom_range(0, 7));
        rsp_ready[c] = ($urandom_range(0, 3) != 0);
      end
      fault_clr = ($urandom_range(0, 31) == 0);
      if (cyc == 700) rst_l = 1'b0;
      if (cyc == 702) rst_l = 1'b1;
      tick();
    end
    cfg_wr_en = 1'b0;
    addr_wr_en = 1'b0;
    fault_clr = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    tick();

    // Drive the fault counter into saturation with every entry OFF
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    tick();
    for (int c = 0; c < NCH; c++) applyStimulus(c, 32'h0000_4000, 3'b001);
    for (int cyc = 0; cyc < 21900; cyc++) tick();
    checkOutput("sat_fault_cnt", 32'(fault_cnt), 32'h0000_FFFF);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    req_valid = '0;
    tick();
    checkOutput("clr_after_sat_cnt", 32'(fault_cnt), 32'd3);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
